ngx_http_parse_time_rfc1123_scan: RTL and testbench
===================================================

# ngx_http_parse_time_rfc1123_scan

Byte-serial front end of the HTTP date parser. Scans one RFC 1123 date string, e.g. "Sun, 06 Nov 1994 08:49:37 GMT", and validates it. Emits a 21-bit unsigned day count since 1970-01-01 and a 17-bit seconds-of-day. The day count feeds the 21ns×18s day×86400 multiplier directly; the seconds value is added to its 40-bit product downstream.

## Interface
- No parameters; all widths fixed.
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  ASCII byte.
- in_valid  in  1  byte present.
- in_last  in  1  final byte of the header value.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- out_days  out  21  days since epoch; zero when out_err.
- out_secs  out  17  h·3600+m·60+s; zero when out_err.
- out_err  out  1  string rejected.
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid & out_ready.

## Operation
- Fixed 29-byte template, byte position counter pos 0..28:
  - pos 0–2: weekday, ASCII letters only; the name is not checked.
  - 3 ',', 4 ' ', 5–6 day digits, 7 ' '.
  - 8–10: month, case-sensitive "Jan".."Dec" → 1..12.
  - 11 ' ', 12–15 year digits, 16 ' ', 17–18 hour, 19 ':', 20–21 min, 22 ':', 23–24 sec, 25 ' ', 26–28 "GMT".
- Digit fields accumulate in decimal as bytes arrive.
- Error conditions, each latching err:
  - byte mismatching the template;
  - in_last at pos<28, or in_last=0 at pos 28;
  - day 0 or day > month length (Feb 29 only in leap years: y%4==0 and (y%100!=0 or y%400==0));
  - year <1970 or >7000;
  - hour >23, min >59, sec >59.
- States:
  - PARSE: in_ready=1.
  - DRAIN: in_ready=1; entered on the first mismatch before in_last; discards bytes until in_last.
  - CALC0, CALC1: in_ready=0.
  - OUT: in_ready=0, out_valid=1.
- Transitions:
  - PARSE: good final byte → CALC0.
  - PARSE: error byte with in_last → OUT (err).
  - PARSE: error byte without in_last → DRAIN.
  - DRAIN: in_last → OUT (err).
  - CALC0 → CALC1.
  - CALC1 → OUT, with err set if the range/leap check fails.
  - OUT: on out_ready → PARSE, pos=0, err=0.
- Day arithmetic, all exact integer:
  - m' = month−2, y' = year; if m' ≤ 0 then m' += 12 and y' −= 1.
  - days = 365y' + y'/4 − y'/100 + y'/400 + ⌊367m'/12⌋ + day − 719499.
  - y'/100 = (y'·5243)>>19; y'/400 = (y'/100)>>2; ⌊367m'/12⌋ comes from a 12-entry LUT.
  - Intermediates use 23 bits. The result always fits 21 bits unsigned because of the year limit.

## Timing
- Reset: in_ready=1, out_valid=0, out_err=0, out_days=0, out_secs=0, pos=0, state PARSE.
- Reset asserted mid-string or mid-result abandons all work; the next accepted byte is pos 0.
- Good string, final byte accepted at cycle t:
  - CALC0 at t+1, CALC1 at t+2.
  - out_valid=1 at t+3, all outputs registered.
- Error string, in_last byte accepted at t: out_valid=1 at t+1.
- Outputs hold stable while out_valid & !out_ready.
- After the out_valid & out_ready cycle, in_ready=1 the following cycle. There is no overlap between strings.
- Throughput: one byte per cycle while in_valid. Bubbles in in_valid are tolerated anywhere.
- in_data, in_last are ignored when in_valid=0.

## Structure
- Package ngx_http_parse_time_pkg holds:
  - the state enum;
  - template constants (separator positions and bytes);
  - month-name table, month-length table, 367m'/12 LUT;
  - constants YEAR_MIN=1970, YEAR_MAX=7000, EPOCH_OFS=719499, DIV100_MUL=5243.
- Sub-module ngx_http_parse_time_days_calc holds the two-stage CALC0/CALC1 pipeline (y'/m' fixup, divides, sum, leap/range check). The scanner FSM, field accumulators and output register stay in the top module.

## Test plan
- "Sun, 06 Nov 1994 08:49:37 GMT", in_valid continuous → out_days=9075, out_secs=31777, out_err=0, out_valid 3 cycles after last byte.
- "Thu, 01 Jan 1970 00:00:00 GMT" with random in_valid gaps and out_ready held low 5 cycles → days=0, secs=0; outputs stable until out_ready.
- "Tue, 29 Feb 2000 23:59:59 GMT" → days=11016, secs=86399, err=0.
  - "Mon, 29 Feb 2100 00:00:00 GMT" → err=1, days=0, secs=0.
  - Year 7001 → err=1.
- "Sun, 06 Xyz 1994 08:49:37 GMT" → DRAIN consumes the remainder; err=1 one cycle after in_last.
  - in_last at pos 10 → err=1.
  - 30-byte string with in_last on byte 29 → err=1.
- Bad hour "24", min "60", sec "60" (separately) → err=1 each.
- ap_rst_n low during byte 15, then a full valid string → first result is correct with no residue.

Source files
------------

// File: rtl/ngx_http_parse_time_pkg.sv
// Shared types, template constants and lookup tables for the RFC 1123 date scanner.
// Lookups are small case-based functions so they synthesise to plain decode logic.
package ngx_http_parse_time_pkg;

    typedef enum logic [2:0] {
        ST_PARSE,
        ST_DRAIN,
        ST_CALC0,
        ST_CALC1,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALPHA,
        CLS_DIGIT,
        CLS_MONTH,
        CLS_LIT
    } tmpl_cls_t;

    localparam logic [4:0] POS_COMMA   = 5'd3;
    localparam logic [4:0] POS_COLON_H = 5'd19;
    localparam logic [4:0] POS_COLON_M = 5'd22;
    localparam logic [4:0] POS_G       = 5'd26;
    localparam logic [4:0] POS_M       = 5'd27;
    localparam logic [4:0] POS_LAST    = 5'd28;

    localparam logic [7:0] CH_COMMA = 8'h2C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_G     = 8'h47;
    localparam logic [7:0] CH_M     = 8'h4D;
    localparam logic [7:0] CH_T     = 8'h54;

    localparam logic [13:0] YEAR_MIN   = 14'd1970;
    localparam logic [13:0] YEAR_MAX   = 14'd7000;
    localparam logic [22:0] EPOCH_OFS  = 23'd719499;
    localparam logic [12:0] DIV100_MUL = 13'd5243;

    function automatic tmpl_cls_t tmpl_class(input logic [4:0] pos);
        case (pos)
            5'd0, 5'd1, 5'd2:                       return CLS_ALPHA;
            5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15,
            5'd17, 5'd18, 5'd20, 5'd21, 5'd23, 5'd24: return CLS_DIGIT;
            5'd8, 5'd9, 5'd10:                      return CLS_MONTH;
            default:                                return CLS_LIT;
        endcase
    endfunction

    function automatic logic [7:0] tmpl_char(input logic [4:0] pos);
        case (pos)
            POS_COMMA:                return CH_COMMA;
            POS_COLON_H, POS_COLON_M: return CH_COLON;
            POS_G:                    return CH_G;
            POS_M:                    return CH_M;
            POS_LAST:                 return CH_T;
            default:                  return CH_SPACE;
        endcase
    endfunction

    function automatic logic is_alpha(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Case-sensitive month name to 1..12; 0 means no match.
    function automatic logic [3:0] month_lookup(input logic [23:0] name);
        case (name)
            24'h4A616E: return 4'd1;   // Jan
            24'h466562: return 4'd2;   // Feb
            24'h4D6172: return 4'd3;   // Mar
            24'h417072: return 4'd4;   // Apr
            24'h4D6179: return 4'd5;   // May
            24'h4A756E: return 4'd6;   // Jun
            24'h4A756C: return 4'd7;   // Jul
            24'h417567: return 4'd8;   // Aug
            24'h536570: return 4'd9;   // Sep
            24'h4F6374: return 4'd10;  // Oct
            24'h4E6F76: return 4'd11;  // Nov
            24'h446563: return 4'd12;  // Dec
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    // floor(367*m'/12) for the March-based month index m' = 1..12.
    function automatic logic [8:0] lut367(input logic [3:0] mp);
        case (mp)
            4'd1:    return 9'd30;
            4'd2:    return 9'd61;
            4'd3:    return 9'd91;
            4'd4:    return 9'd122;
            4'd5:    return 9'd152;
            4'd6:    return 9'd183;
            4'd7:    return 9'd214;
            4'd8:    return 9'd244;
            4'd9:    return 9'd275;
            4'd10:   return 9'd305;
            4'd11:   return 9'd336;
            4'd12:   return 9'd367;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [6:0] dec_acc7(input logic [6:0] f, input logic [3:0] d);
        return (f * 7'd10) + {3'd0, d};
    endfunction

    function automatic logic [13:0] dec_acc14(input logic [13:0] f, input logic [3:0] d);
        return (f * 14'd10) + {10'd0, d};
    endfunction

endpackage

// File: rtl/ngx_http_parse_time_days_calc.sv
// Two-stage day-count pipeline: stage 0 registers the March-based fixup, divides and
// date validity; stage 1 is the combinational sum consumed by the top's output register.
module ngx_http_parse_time_days_calc
    import ngx_http_parse_time_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [13:0] year,
    input  logic [3:0]  month,
    input  logic [6:0]  day,
    output logic [20:0] days,
    output logic        bad
);

    logic [3:0]  mp_c;
    logic [13:0] yp_c;
    logic [7:0]  yp_div100;
    logic [7:0]  yr_div100;
    logic [13:0] yr_hund;
    logic        leap;
    logic        bad_c;

    logic [13:0] yp_q;
    logic [8:0]  lut_q;
    logic [6:0]  day_q;
    logic [7:0]  div100_q;
    logic        bad_q;

    always_comb begin
        mp_c = month - 4'd2;
        yp_c = year;
        if (month <= 4'd2) begin
            mp_c = month + 4'd10;
            yp_c = year - 14'd1;
        end
    end

    // Reciprocal multiply is exact for every year below the 7000 ceiling.
    assign yp_div100 = 8'(({13'd0, yp_c} * {14'd0, DIV100_MUL}) >> 19);
    assign yr_div100 = 8'(({13'd0, year} * {14'd0, DIV100_MUL}) >> 19);
    assign yr_hund   = {6'd0, yr_div100} * 14'd100;

    assign leap  = (year[1:0] == 2'b00) && ((yr_hund != year) || (yr_div100[1:0] == 2'b00));
    assign bad_c = (day == 7'd0) || (day > {2'd0, month_len(month, leap)}) ||
                   (year < YEAR_MIN) || (year > YEAR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yp_q     <= '0;
            lut_q    <= '0;
            day_q    <= '0;
            div100_q <= '0;
            bad_q    <= 1'b0;
        end else if (en) begin
            yp_q     <= yp_c;
            lut_q    <= lut367(mp_c);
            day_q    <= day;
            div100_q <= yp_div100;
            bad_q    <= bad_c;
        end
    end

    // Wraps harmlessly for out-of-range years; the caller zeroes the result on bad.
    assign days = 21'(({9'd0, yp_q} * 23'd365) + {11'd0, yp_q[13:2]} - {15'd0, div100_q}
                      + {17'd0, div100_q[7:2]} + {14'd0, lut_q} + {16'd0, day_q} - EPOCH_OFS);
    assign bad  = bad_q;

endmodule

// File: rtl/ngx_http_parse_time_rfc1123_scan.sv
// Byte-serial RFC 1123 date scanner: template check, field accumulation, result register.
// States: PARSE scan | DRAIN discard to in_last | CALC0/CALC1 day pipeline | OUT hold result.
module ngx_http_parse_time_rfc1123_scan
    import ngx_http_parse_time_pkg::*;
(
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [20:0] out_days,
    output logic [16:0] out_secs,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t      state, state_nxt;
    logic [4:0]  pos;
    logic [6:0]  day, hour, minute, second;
    logic [13:0] year;
    logic [3:0]  month;
    logic [15:0] mon_acc;

    logic [3:0]  digit;
    logic [3:0]  mon_idx;
    logic        byte_bad;
    logic        last_bad;
    logic        tok_bad;
    logic        hms_bad;
    logic        res_bad;
    logic [16:0] secs_c;
    logic [20:0] calc_days;
    logic        calc_bad;

    assign digit    = in_data[3:0];
    assign mon_idx  = month_lookup({mon_acc, in_data});
    assign last_bad = in_last != (pos == POS_LAST);
    assign tok_bad  = byte_bad || last_bad;

    always_comb begin
        byte_bad = 1'b0;
        case (tmpl_class(pos))
            CLS_ALPHA: byte_bad = !is_alpha(in_data);
            CLS_DIGIT: byte_bad = !is_digit(in_data);
            CLS_MONTH: byte_bad = (pos == 5'd10) && (mon_idx == 4'd0);
            default:   byte_bad = in_data != tmpl_char(pos);
        endcase
    end

    assign hms_bad = (hour > 7'd23) || (minute > 7'd59) || (second > 7'd59);
    assign res_bad = hms_bad || calc_bad;
    assign secs_c  = ({10'd0, hour} * 17'd3600) + ({10'd0, minute} * 17'd60) + {10'd0, second};

    ngx_http_parse_time_days_calc u_days_calc (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .en    (state == ST_CALC0),
        .year  (year),
        .month (month),
        .day   (day),
        .days  (calc_days),
        .bad   (calc_bad)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= ST_PARSE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_PARSE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (tok_bad)              state_nxt = in_last ? ST_OUT : ST_DRAIN;
                    else if (pos == POS_LAST) state_nxt = ST_CALC0;
                end
            end
            ST_DRAIN: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_nxt = ST_OUT;
            end
            ST_CALC0: state_nxt = ST_CALC1;
            ST_CALC1: state_nxt = ST_OUT;
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_PARSE;
            end
            default: state_nxt = ST_PARSE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pos      <= '0;
            day      <= '0;
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            year     <= '0;
            month    <= '0;
            mon_acc  <= '0;
            out_days <= '0;
            out_secs <= '0;
            out_err  <= 1'b0;
        end else begin
            case (state)
                ST_PARSE: begin
                    if (in_valid) begin
                        if (pos != POS_LAST) pos <= pos + 5'd1;
                        case (pos)
                            5'd5:                  day     <= {3'd0, digit};
                            5'd6:                  day     <= dec_acc7(day, digit);
                            5'd8:                  mon_acc[15:8] <= in_data;
                            5'd9:                  mon_acc[7:0]  <= in_data;
                            5'd10:                 month   <= mon_idx;
                            5'd12:                 year    <= {10'd0, digit};
                            5'd13, 5'd14, 5'd15:   year    <= dec_acc14(year, digit);
                            5'd17:                 hour    <= {3'd0, digit};
                            5'd18:                 hour    <= dec_acc7(hour, digit);
                            5'd20:                 minute  <= {3'd0, digit};
                            5'd21:                 minute  <= dec_acc7(minute, digit);
                            5'd23:                 second  <= {3'd0, digit};
                            5'd24:                 second  <= dec_acc7(second, digit);
                            default: ;
                        endcase
                        if (tok_bad && in_last) begin
                            out_err  <= 1'b1;
                            out_days <= '0;
                            out_secs <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_valid && in_last) begin
                        out_err  <= 1'b1;
                        out_days <= '0;
                        out_secs <= '0;
                    end
                end
                ST_CALC1: begin
                    out_err  <= res_bad;
                    out_days <= res_bad ? 21'd0 : calc_days;
                    out_secs <= res_bad ? 17'd0 : secs_c;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        pos     <= '0;
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ngx_http_parse_time_rfc1123_scan.sv
// Directed bench for the RFC 1123 date scanner: hand-computed days/secs, latency, errors.
module tb_ngx_http_parse_time_rfc1123_scan;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [20:0] out_days;
    logic [16:0] out_secs;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int total = 0;
    int bad = 0;

    ngx_http_parse_time_rfc1123_scan dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_days  (out_days),
        .out_secs  (out_secs),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send(input string s, input int n, input bit last, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge ap_clk);
                    in_valid = 1'b0;
                    in_data  = 8'hFF;
                    in_last  = 1'b1;
                end
            end
            @(negedge ap_clk);
            in_data  = s[i];
            in_valid = 1'b1;
            in_last  = last && (i == n - 1);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume(input string tag, input int days, input int secs, input bit err);
        chk({tag, "_days"}, {11'd0, out_days}, days);
        chk({tag, "_secs"}, {15'd0, out_secs}, secs);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input string s, input int lat, input int days,
                       input int secs, input bit err);
        int n;
        send(s, s.len(), 1'b1, 1'b0);
        wait_out(tag, n);
        chk({tag, "_lat"}, n, lat);
        consume(tag, days, secs, err);
    endtask

    initial begin
        int n;
        string s;
        logic [20:0] hold_days;
        logic [16:0] hold_secs;

        repeat (2) @(negedge ap_clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_out_days", {11'd0, out_days}, 32'd0);
        chk("rst_out_secs", {15'd0, out_secs}, 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        run("nov1994", "Sun, 06 Nov 1994 08:49:37 GMT", 2, 9075, 31777, 1'b0);

        s = "Thu, 01 Jan 1970 00:00:00 GMT";
        send(s, s.len(), 1'b1, 1'b1);
        wait_out("epoch", n);
        hold_days = out_days;
        hold_secs = out_secs;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("epoch_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("epoch_hold_days", {11'd0, out_days}, {11'd0, hold_days});
            chk("epoch_hold_secs", {15'd0, out_secs}, {15'd0, hold_secs});
        end
        consume("epoch", 0, 0, 1'b0);

        run("leap2000", "Tue, 29 Feb 2000 23:59:59 GMT", 2, 11016, 86399, 1'b0);

        // Abort mid-string while the previous result is still in the output register.
        s = "Sun, 06 Nov 1994 08:49:37 GMT";
        send(s, 15, 1'b0, 1'b0);
        in_data  = s[15];
        in_valid = 1'b1;
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_out_days", {11'd0, out_days}, 32'd0);
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run("after_rst", s, 2, 9075, 31777, 1'b0);

        run("max7000", "Sat, 01 Jan 7000 00:00:00 GMT", 2, 1837170, 0, 1'b0);
        run("feb2100", "Mon, 29 Feb 2100 00:00:00 GMT", 2, 0, 0, 1'b1);
        run("y7001", "Mon, 01 Jan 7001 00:00:00 GMT", 2, 0, 0, 1'b1);
        run("y1969", "Wed, 31 Dec 1969 23:59:59 GMT", 2, 0, 0, 1'b1);
        run("apr31", "Sat, 31 Apr 2021 12:00:00 GMT", 2, 0, 0, 1'b1);
        run("day00", "Sat, 00 Apr 2021 12:00:00 GMT", 2, 0, 0, 1'b1);
        run("hour24", "Sun, 06 Nov 1994 24:49:37 GMT", 2, 0, 0, 1'b1);
        run("min60", "Sun, 06 Nov 1994 08:60:37 GMT", 2, 0, 0, 1'b1);
        run("sec60", "Sun, 06 Nov 1994 08:49:60 GMT", 2, 0, 0, 1'b1);

        run("badmon", "Sun, 06 Xyz 1994 08:49:37 GMT", 0, 0, 0, 1'b1);
        run("short", "Sun, 06 Nov", 0, 0, 0, 1'b1);
        run("long", "Sun, 06 Nov 1994 08:49:37 GMTX", 0, 0, 0, 1'b1);
        run("badsep", "Sun; 06 Nov 1994 08:49:37 GMT", 0, 0, 0, 1'b1);

        run("recover", "Sun, 06 Nov 1994 08:49:37 GMT", 2, 9075, 31777, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
